// File: rtl/colour_map_pipe.sv
// colour_map_pipe: three-stage iteration-count to RGB mapper.
// S1 captures the beat with its frame config, S2 normalises the count to
// 8 bits against max_iter, S3 forms the colour (XOR patterns or palette).
//
// Handshake: a beat moves on a rising clk edge when valid and ready are
// both high. in_ready_o = out_ready_i | ~out_valid_o. Every stage shifts
// together on that advance. While out_valid_o=1 and out_ready_i=0, all
// outputs hold their values.
module colour_map_pipe #(
  parameter int ITER_WIDTH  = 16,
  parameter bit INSET_BLACK = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ITER_WIDTH-1:0] max_iter_i,
  input  logic [1:0]            mode_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ITER_WIDTH-1:0] iter_i,
  input  logic                  sof_i,
  input  logic                  eol_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [7:0]            r_o,
  output logic [7:0]            g_o,
  output logic [7:0]            b_o,
  output logic                  sof_o,
  output logic                  eol_o,
  input  logic                  pal_we_i,
  input  logic [7:0]            pal_addr_i,
  input  logic [23:0]           pal_data_i
);

  logic                  adv;
  logic                  accept;

  // Frame configuration latched on sof beats
  logic [ITER_WIDTH-1:0] cfg_max_q;
  logic [1:0]            cfg_mode_q;
  logic [ITER_WIDTH-1:0] eff_max;
  logic [1:0]            eff_mode;

  // Stage 1
  logic                  s1_valid;
  logic [ITER_WIDTH-1:0] s1_iter;
  logic [ITER_WIDTH-1:0] s1_max;
  logic [1:0]            s1_mode;
  logic                  s1_sof;
  logic                  s1_eol;

  // Stage 2
  int                    msb;
  logic [ITER_WIDTH-1:0] scaled;
  logic                  black;
  logic                  s2_valid;
  logic [7:0]            s2_s;
  logic                  s2_black;
  logic [1:0]            s2_mode;
  logic                  s2_sof;
  logic                  s2_eol;

  // Stage 3
  logic [7:0]            pat_a;
  logic [7:0]            pat_b;
  logic [7:0]            pat_c;
  logic [23:0]           rgb_next;
  logic [23:0]           s3_rgb;
  logic                  s3_pal_sel;
  logic                  s3_sof;
  logic                  s3_eol;
  logic [23:0]           pal_q;
  logic [23:0]           pal_mem [0:255];

  assign adv        = out_ready_i | ~out_valid_o;
  assign in_ready_o = adv;
  assign accept     = in_valid_i & adv;

  // A sof beat uses its own config; other beats use the latched one
  assign eff_max  = sof_i ? max_iter_i : cfg_max_q;
  assign eff_mode = sof_i ? mode_i     : cfg_mode_q;

  // Latch the frame config when a sof beat is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_max_q  <= '0;
      cfg_mode_q <= '0;
    end else if (accept && sof_i) begin
      cfg_max_q  <= max_iter_i;
      cfg_mode_q <= mode_i;
    end
  end

  // S1: register the beat together with the config it must be coloured with
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_iter  <= '0;
      s1_max   <= '0;
      s1_mode  <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid_i;
      s1_iter  <= iter_i;
      s1_max   <= eff_max;
      s1_mode  <= eff_mode;
      s1_sof   <= sof_i;
      s1_eol   <= eol_i;
    end
  end

  // Normalise the count so that max_iter's top bit lands on bit 7
  always_comb begin
    msb = 0;
    for (int i = 0; i < ITER_WIDTH; i++) begin
      if (s1_max[i]) msb = i;
    end
    if (msb > 7) scaled = s1_iter >> (msb - 7);
    else         scaled = s1_iter << (7 - msb);
    black = (s1_max == '0) || (INSET_BLACK && (s1_iter >= s1_max));
  end

  // S2: register the 8-bit scaled value and the black override
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_black <= 1'b0;
      s2_mode  <= '0;
      s2_sof   <= 1'b0;
      s2_eol   <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_s     <= scaled[7:0];
      s2_black <= black;
      s2_mode  <= s1_mode;
      s2_sof   <= s1_sof;
      s2_eol   <= s1_eol;
    end
  end

  // XOR patterns and per-mode channel assignment
  always_comb begin
    pat_a    = s2_s ^ {1'b0, s2_s[5:0], 1'b0};
    pat_b    = {1'b0, s2_s[6:0]} ^ {2'b00, s2_s[3:0], 2'b00};
    pat_c    = {s2_s[4:0], 3'b000} ^ {5'b00000, s2_s[2:0]};
    rgb_next = '0;
    case (s2_mode)
      2'd0:    rgb_next = {pat_a, pat_b, pat_c};
      2'd1:    rgb_next = {pat_b, pat_c, pat_a};
      2'd2:    rgb_next = {pat_c, pat_a, pat_b};
      default: rgb_next = '0;
    endcase
    if (s2_black) rgb_next = '0;
  end

  // S3: output register; selects the palette read when mode 3 is not black
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      s3_rgb      <= '0;
      s3_pal_sel  <= 1'b0;
      s3_sof      <= 1'b0;
      s3_eol      <= 1'b0;
    end else if (adv) begin
      out_valid_o <= s2_valid;
      s3_rgb      <= rgb_next;
      s3_pal_sel  <= ~s2_black && (s2_mode == 2'd3);
      s3_sof      <= s2_sof;
      s3_eol      <= s2_eol;
    end
  end

  // Palette RAM: write any time, read only when S3 advances (old data on collision)
  always_ff @(posedge clk_i) begin
    if (pal_we_i) pal_mem[pal_addr_i] <= pal_data_i;
    if (adv)      pal_q <= pal_mem[s2_s];
  end

  assign {r_o, g_o, b_o} = s3_pal_sel ? pal_q : s3_rgb;
  assign sof_o = s3_sof;
  assign eol_o = s3_eol;

endmodule

// File: tb/tb_colour_map_pipe.sv
// tb_colour_map_pipe: table vectors, palette corner cases, random stream
// with backpressure, and mid-frame reset for colour_map_pipe.
module tb_colour_map_pipe;
  localparam int W = 16;

  // Clock / reset and DUT signals
  logic         clk = 1'b0;
  logic         rst_ni;
  logic [W-1:0] max_iter_i;
  logic [1:0]   mode_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] iter_i;
  logic         sof_i;
  logic         eol_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [7:0]   r_o, g_o, b_o;
  logic         sof_o, eol_o;
  logic         pal_we_i;
  logic [7:0]   pal_addr_i;
  logic [23:0]  pal_data_i;

  colour_map_pipe #(.ITER_WIDTH(W), .INSET_BLACK(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .max_iter_i(max_iter_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .iter_i(iter_i),
    .sof_i(sof_i), .eol_i(eol_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .sof_o(sof_o), .eol_o(eol_o), .pal_we_i(pal_we_i),
    .pal_addr_i(pal_addr_i), .pal_data_i(pal_data_i)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [25:0] exp_q[$];
  logic [23:0] pal_model [256];
  int unsigned m_max  = 0;
  int unsigned m_mode = 0;
  logic        prev_stall = 1'b0;
  logic [25:0] prev_out;
  logic        rand_ready = 1'b0;
  logic        ready_val  = 1'b1;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] mx;
    logic [1:0]  md;
    logic [15:0] it;
    logic [23:0] rgb;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference colour from the arithmetic definition of the mapping
  function automatic logic [23:0] ref_rgb(input int unsigned it, input int unsigned mx,
                                          input int unsigned md);
    int unsigned p, t, sc, s, a, b, c;
    if (mx == 0 || it >= mx) return 24'h0;
    p = 0;
    t = mx;
    while (t > 1) begin t = t / 2; p++; end
    if (p > 7) sc = it / (1 << (p - 7));
    else       sc = it * (1 << (7 - p));
    s = sc % 256;
    a = (s ^ ((s % 64) * 2)) % 256;
    b = ((s % 128) ^ ((s % 16) * 4)) % 256;
    c = (((s % 32) * 8) ^ (s % 8)) % 256;
    case (md)
      0: return {a[7:0], b[7:0], c[7:0]};
      1: return {b[7:0], c[7:0], a[7:0]};
      2: return {c[7:0], a[7:0], b[7:0]};
      default: return pal_model[s];
    endcase
  endfunction

  // Monitor: handshake rule, hold under stall, ordered output vs model
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      m_max      = 0;
      m_mode     = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", {31'b0, in_ready_o}, {31'b0, out_ready_i | ~out_valid_o});
      if (prev_stall) begin
        check("hold_valid", {31'b0, out_valid_o}, 32'd1);
        check("hold_data", {6'b0, sof_o, eol_o, r_o, g_o, b_o}, {6'b0, prev_out});
      end
      prev_stall = out_valid_o & ~out_ready_i;
      prev_out   = {sof_o, eol_o, r_o, g_o, b_o};
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0)
          check("unexpected_out", {6'b0, sof_o, eol_o, r_o, g_o, b_o}, 32'hFFFFFFFF);
        else
          check("stream_out", {6'b0, sof_o, eol_o, r_o, g_o, b_o}, {6'b0, exp_q.pop_front()});
      end
      if (in_valid_i && in_ready_o) begin
        if (sof_i) begin
          m_max  = max_iter_i;
          m_mode = mode_i;
        end
        exp_q.push_back({sof_i, eol_i, ref_rgb(iter_i, m_max, m_mode)});
      end
    end
  end

  // Downstream ready driver
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Driver: present one beat (called at posedge+1) and wait for acceptance
  task automatic send_beat(input logic sof, input logic eol, input logic [15:0] mx,
                           input logic [1:0] md, input logic [15:0] it);
    int   guard = 0;
    logic acc   = 1'b0;
    sof_i = sof; eol_i = eol; max_iter_i = mx; mode_i = md; iter_i = it;
    in_valid_i = 1'b1;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid_i = 1'b0;
    check("send_accept", {31'b0, acc}, 32'd1);
  endtask

  // Count cycles until out_valid_o is seen (called right after send_beat)
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pal_write(input logic [7:0] addr, input logic [23:0] data);
    pal_we_i = 1'b1; pal_addr_i = addr; pal_data_i = data;
    @(posedge clk);
    #1;
    pal_we_i = 1'b0;
    pal_model[addr] = data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    int lat;
    vecs[0]  = '{1'b1, 1'b0, 16'd256,   2'd0, 16'd200,    24'h2C7424};
    vecs[1]  = '{1'b1, 1'b1, 16'd100,   2'd0, 16'd50,     24'h2C7424};
    vecs[2]  = '{1'b0, 1'b0, 16'd100,   2'd0, 16'd100,    24'h000000};
    vecs[3]  = '{1'b1, 1'b0, 16'd256,   2'd1, 16'd200,    24'h74242C};
    vecs[4]  = '{1'b1, 1'b1, 16'd256,   2'd2, 16'd200,    24'h242C74};
    vecs[5]  = '{1'b0, 1'b0, 16'd16,    2'd0, 16'd200,    24'h242C74};
    vecs[6]  = '{1'b1, 1'b0, 16'd0,     2'd0, 16'd5,      24'h000000};
    vecs[7]  = '{1'b1, 1'b0, 16'd256,   2'd0, 16'd256,    24'h000000};
    vecs[8]  = '{1'b1, 1'b1, 16'd256,   2'd0, 16'd255,    24'h0143FF};
    vecs[9]  = '{1'b1, 1'b0, 16'd2,     2'd0, 16'd1,      24'h404000};
    vecs[10] = '{1'b1, 1'b0, 16'hFFFF,  2'd0, 16'h8000,   24'h800000};

    rst_ni = 1'b0;
    in_valid_i = 1'b0; sof_i = 1'b0; eol_i = 1'b0; iter_i = '0;
    max_iter_i = '0; mode_i = '0;
    pal_we_i = 1'b0; pal_addr_i = '0; pal_data_i = '0;

    // Reset state
    #12;
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_rgb", {8'b0, r_o, g_o, b_o}, 32'd0);
    check("rst_markers", {30'b0, sof_o, eol_o}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
    #10;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors with an idle pipeline: latency, colour, markers
    for (int i = 0; i < 11; i++) begin
      send_beat(vecs[i].sof, vecs[i].eol, vecs[i].mx, vecs[i].md, vecs[i].it);
      wait_out(lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_rgb", i), {8'b0, r_o, g_o, b_o}, {8'b0, vecs[i].rgb});
      check($sformatf("vec%0d_markers", i), {30'b0, sof_o, eol_o}, {30'b0, vecs[i].sof, vecs[i].eol});
    end

    // Palette: fill with random data, then the known entry
    for (int a = 0; a < 256; a++) pal_write(8'(a), 24'($urandom));
    pal_write(8'h64, 24'h123456);

    send_beat(1'b1, 1'b0, 16'd256, 2'd3, 16'd200);
    wait_out(lat);
    check("pal_rgb", {8'b0, r_o, g_o, b_o}, 32'h00123456);

    // Same-cycle write and read of 0x64 returns the old entry
    send_beat(1'b0, 1'b0, 16'd0, 2'd0, 16'd200);
    @(posedge clk);
    #1;
    pal_we_i = 1'b1; pal_addr_i = 8'h64; pal_data_i = 24'hABCDEF;
    @(posedge clk);
    #1;
    pal_we_i = 1'b0;
    check("pal_collide_valid", {31'b0, out_valid_o}, 32'd1);
    check("pal_collide_old", {8'b0, r_o, g_o, b_o}, 32'h00123456);
    pal_model[8'h64] = 24'hABCDEF;
    send_beat(1'b0, 1'b0, 16'd0, 2'd0, 16'd200);
    wait_out(lat);
    check("pal_new", {8'b0, r_o, g_o, b_o}, 32'h00ABCDEF);

    // Random stream under random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int unsigned mx, it;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      mx = $urandom_range(1, 65535) >> $urandom_range(0, 15);
      it = $urandom_range(0, mx + mx / 4 + 2);
      if (it > 65535) it = 65535;
      send_beat((n == 0) || ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                16'(mx), 2'($urandom_range(0, 3)), 16'(it));
    end
    rand_ready = 1'b0;
    for (int g = 0; g < 300 && exp_q.size() != 0; g++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 32'd0);

    // Mid-frame reset with three beats in flight and output stalled
    ready_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(1'b1, 1'b0, 16'd256, 2'd0, 16'd10);
    send_beat(1'b0, 1'b0, 16'd256, 2'd0, 16'd20);
    send_beat(1'b0, 1'b1, 16'd256, 2'd0, 16'd30);
    check("pre_rst_valid", {31'b0, out_valid_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("async_rst_rgb", {8'b0, r_o, g_o, b_o}, 32'd0);
    check("async_rst_markers", {30'b0, sof_o, eol_o}, 32'd0);
    ready_val = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    send_beat(1'b0, 1'b0, 16'd100, 2'd1, 16'd5);
    wait_out(lat);
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_black", {8'b0, r_o, g_o, b_o}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("final_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/colour_map_pipe.md
Name: colour_map_pipe

Overview:
- Pipelined, parametrised successor to the combinational iteration-to-RGB mapper. Sits between the fractal iteration engine output stream and the pixel packer / VDMA.
- Accepts one iteration count per beat over a valid/ready stream and normalises it to the frame's max_iter. It emits 24-bit RGB through one of three XOR-pattern schemes or a host-writable 256-entry palette.
- Frame configuration (max_iter, mode) is latched on start-of-frame, so it is stable for the whole frame.

Parameters:
- ITER_WIDTH, 16, width of iteration count and max_iter (8..32).
- INSET_BLACK, 1, when 1 a pixel with iter >= max_iter (point in set) maps to black.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- max_iter_i  in  ITER_WIDTH  frame max iteration; sampled on accepted beat with sof_i=1
- mode_i  in  2  colour scheme; sampled with max_iter_i
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept beat
- iter_i  in  ITER_WIDTH  iteration count of pixel
- sof_i  in  1  first pixel of frame
- eol_i  in  1  last pixel of line
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts
- r_o, g_o, b_o  out  8 each  pixel colour
- sof_o, eol_o  out  1 each  markers delayed with pixel
- pal_we_i  in  1  palette write strobe
- pal_addr_i  in  8  palette write address
- pal_data_i  in  24  palette write data {r,g,b}

Behaviour:
- Reset (rst_ni low, async): out_valid_o=0, r/g/b_o=0, sof_o=eol_o=0, all stage valids=0, latched max_iter=0, latched mode=0. Palette RAM is not reset; its contents are undefined until written.
- Pipeline, 3 stages, latency 3 accepted-beat cycles with no stall:
  - S1 registers iter, markers and the effective config.
  - S2 computes scaled.
  - S3 forms RGB and performs the palette read.
- Throughput is 1 beat/cycle.
- Stall: adv = out_ready_i | ~out_valid_o. All stages shift only when adv=1. in_ready_o = adv. Output data and markers hold while out_valid_o=1 and out_ready_i=0. Beats are never dropped or duplicated.
- Config latch: on an accepted beat with sof_i=1, max_iter_i and mode_i are captured, and that same beat already uses the new values. Beats without sof use the latched values. A pipeline already holding older-frame beats finishes them with their own config, because config travels with each beat.
- Normalisation: p = index of the highest set bit of max_iter.
  - scaled = iter >> (p-7) if p>7.
  - scaled = iter << (7-p) if p<=7.
  - scaled is truncated to ITER_WIDTH. Only scaled[7:0] is used afterwards.
- Patterns, all 8-bit truncating, s=scaled[7:0]:
  - A = s ^ (s[5:0]<<1)
  - B = s[6:0] ^ (s[3:0]<<2)
  - C = (s[4:0]<<3) ^ s[2:0]
- Modes:
  - 0: r=A, g=B, b=C
  - 1: r=B, g=C, b=A
  - 2: r=C, g=A, b=B
  - 3: {r,g,b} = palette[s]
- Black override takes priority over all modes: r=g=b=0 if max_iter==0, or if INSET_BLACK=1 and iter>=max_iter.
- Palette:
  - Single write port and a registered read in S3.
  - Writes take effect on the next clock edge, independent of stall.
  - A same-cycle write and read at the same address returns the old data.
  - A palette read occurs only when S3 advances, so output stays stable under stall.
- Markers sof_o and eol_o are aligned exactly with their pixel.
- Reset mid-frame flushes all in-flight beats with no output. The next frame must start with sof_i=1, otherwise config is max_iter=0 and output is black.

Test Plan:
- Mode 0, max_iter=256, sof beat iter=200 -> after 3 cycles out_valid_o=1, r=0x2C, g=0x74, b=0x24, sof_o=1.
- Mode 0, max_iter=100, iter=50 -> scaled=0x64, same RGB 0x2C/0x74/0x24. Then iter=100 with INSET_BLACK=1 -> 0/0/0.
- Modes 1 and 2, max_iter=256, iter=200 -> mode 1 gives r=0x74, g=0x24, b=0x2C; mode 2 gives r=0x24, g=0x2C, b=0x74. Mode changes only on sof beats.
- Mode 3: write palette[0x64]=0x123456, then max_iter=256, iter=200 -> r=0x12, g=0x34, b=0x56. Write the same address in the read cycle -> old value returned.
- Backpressure: stream 10 beats, toggle out_ready_i randomly -> outputs match the reference order exactly, hold stable under stall, in_ready_o = out_ready_i | ~out_valid_o.
- Assert rst_ni low with 3 beats in flight -> out_valid_o drops to 0 immediately (async). Post-reset beat without sof gives 0/0/0.
